eth_tx_scheduler: RTL and testbench
===================================

Name: eth_tx_scheduler

Overview:
Two-source Ethernet transmit scheduler that drives the byte interface (tx_data/tx_valid) of the RGMII transmit block.
- Arbitrates whole frames between two byte-stream sources, round-robin.
- Prepends preamble and SFD, enforces the inter-frame gap, and handles source underrun.
- Sits between the MAC-side frame sources and the RGMII transmitter, in the tx_clk domain.

Parameters:
PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD (1..15)
IFG_BYTES, 12, minimum idle cycles (tx_valid low) between frames (1..255)
MIN_FRAME, 60, minimum payload byte count when padding is compiled in (1..65535)

Ports:
tx_clk  in  1  transmit byte clock; all logic on rising edge
rst  in  1  synchronous active-high reset
s0_data  in  8  source 0 byte
s0_valid  in  1  source 0 byte valid
s0_last  in  1  source 0 last byte of frame
s0_ready  out  1  source 0 byte accepted this cycle when valid&ready
s1_data  in  8  source 1 byte
s1_valid  in  1  source 1 byte valid
s1_last  in  1  source 1 last byte of frame
s1_ready  out  1  source 1 byte accepted this cycle when valid&ready
tx_data  out  8  byte to RGMII transmitter (registered)
tx_valid  out  1  byte valid to RGMII transmitter (registered)
busy  out  1  high in any state other than IDLE
grant  out  1  source index of current or last frame
frame_done  out  1  one-cycle pulse when the last frame byte is presented on tx_data
underrun  out  1  one-cycle pulse when the granted source drops valid mid-frame

Behaviour:
Reset (rst=1 at an edge, any state):
- state=IDLE; tx_data=0x00, tx_valid=0, s0_ready=s1_ready=0, busy=0, grant=0, frame_done=0, underrun=0.
- Round-robin pointer set so source 0 wins the first tie. No IFG is owed after reset.
- Reset mid-frame truncates the frame immediately; tx_valid goes low at that edge.

States:
- IDLE: if any sN_valid, latch grant. One valid: that source. Both valid: the source not served last. Go to PREAMBLE.
- PREAMBLE: present 0x55 for PREAMBLE_BYTES cycles, then SFD.
- SFD: present 0xD5 for 1 cycle; granted sN_ready=1 in this cycle.
- PAYLOAD: granted sN_ready=1 combinationally.
  - Each valid&ready byte is registered onto tx_data with tx_valid=1 next cycle.
  - On a byte with last=1: ready drops, and the byte's tx cycle pulses frame_done. Go to IFG (or PAD, see Optional Feature).
- DRAIN: see Underrun.
- IFG: tx_valid=0, tx_data=0x00 for exactly IFG_BYTES cycles, then IDLE. IDLE may grant in its first cycle.

Timing:
- Request sampled in IDLE at cycle 0 → tx_valid=1 from cycle 1.
- 0x55 on cycles 1..PREAMBLE_BYTES; 0xD5 on cycle PREAMBLE_BYTES+1.
- Payload byte n on cycle PREAMBLE_BYTES+2+n when the source holds valid continuously.
- Back-to-back minimum spacing between frames: last byte at cycle k → next preamble no earlier than k+IFG_BYTES+2 (IFG_BYTES idle cycles plus one IDLE arbitration cycle).

Ready and arbitration rules:
- Ungranted source ready is always 0.
- A source may not be regranted while its frame is in progress.
- Arbitration occurs only in IDLE, never mid-frame.

Underrun:
- Trigger: in SFD or PAYLOAD, the granted sN_valid is 0 in a ready cycle.
- Response: tx_valid=0 next cycle, truncating the frame; underrun pulses that cycle; no frame_done.
- Enter DRAIN: ready held 1, bytes discarded (tx_valid stays 0) until a byte with last=1 is accepted, then IFG.

Payload counter:
- 16-bit, cleared in IDLE, incremented per accepted payload byte.
- Saturates at 0xFFFF; no wrap.

Optional Feature:
Macro ETH_TX_PAD_EN.
- Defined: adds a PAD state. After the last payload byte, if payload count < MIN_FRAME, present 0x00 with tx_valid=1 until count==MIN_FRAME. frame_done then pulses on the final pad byte instead of the last source byte, followed by IFG. Frames already ≥ MIN_FRAME are unaffected. After an underrun, padding is skipped.
- Undefined: no PAD state; frames are transmitted at source length.

Test Plan:
- Single frame, s0 bytes 0x11,0x22,0x33 (last on 0x33), default params → tx_data 0x55×7, 0xD5, 0x11,0x22,0x33 on cycles 1..11; frame_done on cycle 11; tx_valid=0 on cycles 12..23.
- s0 and s1 both request in the same IDLE cycle after reset → s0 frame first, s1 frame next. Repeat the tie → s1 first (alternation).
- Back-to-back s0 frames, IFG_BYTES=12 → exactly 12 idle cycles plus 1 IDLE cycle between last byte and next 0x55.
- s1 drops valid after 2 of 5 payload bytes → tx_valid low next cycle, underrun=1 for one cycle, remaining bytes drained, no frame_done, IFG then IDLE.
- ETH_TX_PAD_EN, MIN_FRAME=60, 10-byte frame → 50 bytes 0x00 follow payload; frame_done on the 60th payload-stage byte.
- rst asserted during payload byte 4 → next cycle tx_valid=0, busy=0, ready=0. A new s1 request then receives preamble with no IFG delay.

Source files
------------

// File: rtl/eth_tx_scheduler.sv
// Two-source Ethernet transmit scheduler feeding the RGMII transmit byte interface.
// Arbitrates whole frames round-robin, prepends preamble/SFD, enforces the
// inter-frame gap and truncates frames on source underrun.
// Optional padding to MIN_FRAME bytes is compiled in with `define ETH_TX_PAD_EN.
module eth_tx_scheduler #(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned IFG_BYTES      = 12,
    parameter int unsigned MIN_FRAME      = 60
) (
    input  logic       tx_clk,
    input  logic       rst,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       grant,
    output logic       frame_done,
    output logic       underrun
);

`ifdef ETH_TX_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    localparam logic [7:0]  PreLen = 8'(PREAMBLE_BYTES);
    localparam logic [7:0]  IfgLen = 8'(IFG_BYTES);
    localparam logic [15:0] MinLen = 16'(MIN_FRAME);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StPayload,
        StDrain,
        StIfg,
        StPad
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic        grant_q, grant_d;
    logic        prio_q, prio_d;       // source preferred on a tie
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;

    logic        sel_valid;
    logic        sel_last;
    logic [7:0]  sel_data;
    logic        src_ready;
    logic [15:0] pay_inc;

    // Granted-source view, ready strobes and saturating payload count
    always_comb begin
        sel_valid = grant_q ? s1_valid : s0_valid;
        sel_last  = grant_q ? s1_last  : s0_last;
        sel_data  = grant_q ? s1_data  : s0_data;
        src_ready = (state_q == StSfd) || (state_q == StPayload) || (state_q == StDrain);
        s0_ready  = src_ready && !grant_q;
        s1_ready  = src_ready && grant_q;
        pay_inc   = (pay_cnt_q == 16'hFFFF) ? pay_cnt_q : pay_cnt_q + 16'd1;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pay_cnt_d    = pay_cnt_q;
        grant_d      = grant_q;
        prio_d       = prio_q;
        tx_data_d    = 8'h00;
        tx_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                pay_cnt_d = 16'd0;
                cnt_d     = 8'd0;
                if (s0_valid || s1_valid) begin
                    grant_d    = (s0_valid && s1_valid) ? prio_q : s1_valid;
                    prio_d     = ~grant_d;
                    tx_data_d  = 8'h55;
                    tx_valid_d = 1'b1;
                    cnt_d      = 8'd1;
                    state_d    = StPreamble;
                end
            end
            StPreamble: begin
                tx_valid_d = 1'b1;
                if (cnt_q < PreLen) begin
                    tx_data_d = 8'h55;
                    cnt_d     = cnt_q + 8'd1;
                end else begin
                    tx_data_d = 8'hD5;
                    state_d   = StSfd;
                end
            end
            StSfd, StPayload: begin
                if (sel_valid) begin
                    tx_data_d  = sel_data;
                    tx_valid_d = 1'b1;
                    pay_cnt_d  = pay_inc;
                    state_d    = StPayload;
                    if (sel_last) begin
                        cnt_d = 8'd0;
                        if (PadEn && (pay_inc < MinLen)) begin
                            state_d = StPad;
                        end else begin
                            frame_done_d = 1'b1;
                            state_d      = StIfg;
                        end
                    end
                end else begin
                    // Source starved a ready cycle: truncate and discard the rest
                    underrun_d = 1'b1;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (sel_valid && sel_last) begin
                    cnt_d   = 8'd0;
                    state_d = StIfg;
                end
            end
            StIfg: begin
                // IFG_BYTES idle cycles on the wire, then one IDLE arbitration cycle
                if (cnt_q == IfgLen) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StPad: begin
                tx_valid_d = 1'b1;
                pay_cnt_d  = pay_inc;
                if (pay_inc == MinLen) begin
                    frame_done_d = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = StIfg;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            pay_cnt_q    <= 16'd0;
            grant_q      <= 1'b0;
            prio_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pay_cnt_q    <= pay_cnt_d;
            grant_q      <= grant_d;
            prio_q       <= prio_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != StIdle);
    assign grant      = grant_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler with default parameters.
// Sources are queue-driven; gap entries force one valid-low cycle.
module tb_eth_tx_scheduler;

    logic       tx_clk = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] s0_data, s1_data;
    logic       s0_valid, s0_last, s0_ready;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] tx_data;
    logic       tx_valid, busy, grant, frame_done, underrun;

    eth_tx_scheduler dut (
        .tx_clk     (tx_clk),
        .rst        (rst),
        .s0_data    (s0_data),
        .s0_valid   (s0_valid),
        .s0_last    (s0_last),
        .s0_ready   (s0_ready),
        .s1_data    (s1_data),
        .s1_valid   (s1_valid),
        .s1_last    (s1_last),
        .s1_ready   (s1_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .grant      (grant),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial forever #5 tx_clk = ~tx_clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       g;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];

    function automatic ent_t mk(input logic [7:0] d, input logic l, input logic g);
        ent_t e;
        e.d = d;
        e.l = l;
        e.g = g;
        return e;
    endfunction

    int cyc = 0;
    logic [7:0] ld[4096];
    logic       lv[4096];
    logic       lfd[4096];
    logic       lur[4096];
    logic       lbusy[4096];
    logic       lgr[4096];

    initial forever begin
        @(posedge tx_clk);
        cyc = cyc + 1;
    end

    // Per-cycle trace of DUT outputs, sampled mid-cycle
    initial forever begin
        @(posedge tx_clk);
        #4;
        if (cyc < 4096) begin
            ld[cyc]    = tx_data;
            lv[cyc]    = tx_valid;
            lfd[cyc]   = frame_done;
            lur[cyc]   = underrun;
            lbusy[cyc] = busy;
            lgr[cyc]   = grant;
        end
    end

    initial begin : drv0
        logic acc0;
        logic gap0;
        gap0 = 1'b0;
        s0_valid = 1'b0;
        s0_data  = 8'h00;
        s0_last  = 1'b0;
        forever begin
            @(negedge tx_clk);
            acc0 = s0_valid && s0_ready;
            @(posedge tx_clk);
            #1;
            if ((acc0 || gap0) && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                s0_valid = !q0[0].g;
                s0_data  = q0[0].d;
                s0_last  = q0[0].l;
                gap0     = q0[0].g;
            end else begin
                s0_valid = 1'b0;
                s0_data  = 8'h00;
                s0_last  = 1'b0;
                gap0     = 1'b0;
            end
        end
    end

    initial begin : drv1
        logic acc1;
        logic gap1;
        gap1 = 1'b0;
        s1_valid = 1'b0;
        s1_data  = 8'h00;
        s1_last  = 1'b0;
        forever begin
            @(negedge tx_clk);
            acc1 = s1_valid && s1_ready;
            @(posedge tx_clk);
            #1;
            if ((acc1 || gap1) && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                s1_valid = !q1[0].g;
                s1_data  = q1[0].d;
                s1_last  = q1[0].l;
                gap1     = q1[0].g;
            end else begin
                s1_valid = 1'b0;
                s1_data  = 8'h00;
                s1_last  = 1'b0;
                gap1     = 1'b0;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge tx_clk);
        #4;
    endtask

    initial begin : main
        int t0;
        int t1;

        // Reset state
        rst = 1'b1;
        step(3);
        chk("rst_tx_valid", 16'(tx_valid), 16'h0);
        chk("rst_tx_data", 16'(tx_data), 16'h00);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_ready", 16'({s1_ready, s0_ready}), 16'h0);
        chk("rst_pulses", 16'({underrun, frame_done}), 16'h0);
        rst = 1'b0;
        step(2);

        // Tie right after reset: s0 first, then s1
        t0 = cyc + 1;
        q0.push_back(mk(8'hA1, 1'b0, 1'b0));
        q0.push_back(mk(8'hA2, 1'b1, 1'b0));
        q1.push_back(mk(8'hB1, 1'b0, 1'b0));
        q1.push_back(mk(8'hB2, 1'b1, 1'b0));
        step(50);
        chk("tie1_grant_first", 16'(lgr[t0+1]), 16'h0);
        chk("tie1_a1", 16'(ld[t0+9]), 16'hA1);
        chk("tie1_a2_done", 16'({lfd[t0+10], ld[t0+10]}), 16'h1A2);
        chk("tie1_idle_before", 16'(lv[t0+23]), 16'h0);
        chk("tie1_s1_pre", 16'({lv[t0+24], ld[t0+24]}), 16'h155);
        chk("tie1_grant_second", 16'(lgr[t0+24]), 16'h1);
        chk("tie1_s1_sfd", 16'(ld[t0+31]), 16'hD5);
        chk("tie1_b1", 16'(ld[t0+32]), 16'hB1);
        chk("tie1_b2_done", 16'({lfd[t0+33], ld[t0+33]}), 16'h1B2);

        // Back-to-back s0 frames with exact gap
        t0 = cyc + 1;
        q0.push_back(mk(8'h11, 1'b0, 1'b0));
        q0.push_back(mk(8'h22, 1'b0, 1'b0));
        q0.push_back(mk(8'h33, 1'b1, 1'b0));
        q0.push_back(mk(8'h44, 1'b0, 1'b0));
        q0.push_back(mk(8'h55, 1'b1, 1'b0));
        step(52);
        chk("b2b_idle_at_req", 16'(lv[t0]), 16'h0);
        for (int i = 1; i <= 7; i++) chk("b2b_preamble", 16'({lv[t0+i], ld[t0+i]}), 16'h155);
        chk("b2b_sfd", 16'({lv[t0+8], ld[t0+8]}), 16'h1D5);
        chk("b2b_byte0", 16'(ld[t0+9]), 16'h11);
        chk("b2b_byte1", 16'({lfd[t0+10], ld[t0+10]}), 16'h022);
        chk("b2b_byte2_done", 16'({lfd[t0+11], lv[t0+11], ld[t0+11]}), 16'h333);
        for (int i = 12; i <= 24; i++) chk("b2b_gap", 16'({lv[t0+i], ld[t0+i]}), 16'h000);
        chk("b2b_next_pre", 16'({lv[t0+25], ld[t0+25]}), 16'h155);
        chk("b2b_next_sfd", 16'(ld[t0+32]), 16'hD5);
        chk("b2b_f2_byte0", 16'(ld[t0+33]), 16'h44);
        chk("b2b_f2_done", 16'({lfd[t0+34], ld[t0+34]}), 16'h155);

        // Tie again, s0 served last: s1 wins
        t0 = cyc + 1;
        q0.push_back(mk(8'hC1, 1'b1, 1'b0));
        q1.push_back(mk(8'hD1, 1'b1, 1'b0));
        step(48);
        chk("tie2_grant_first", 16'(lgr[t0+1]), 16'h1);
        chk("tie2_d1_done", 16'({lfd[t0+9], ld[t0+9]}), 16'h1D1);
        chk("tie2_gap_end", 16'(lv[t0+22]), 16'h0);
        chk("tie2_grant_second", 16'({lgr[t0+23], lv[t0+23]}), 16'h1);
        chk("tie2_c1_done", 16'({lfd[t0+31], ld[t0+31]}), 16'h1C1);

        // Underrun on s1 after two of five bytes
        t0 = cyc + 1;
        q1.push_back(mk(8'h01, 1'b0, 1'b0));
        q1.push_back(mk(8'h02, 1'b0, 1'b0));
        q1.push_back(mk(8'h00, 1'b0, 1'b1));
        q1.push_back(mk(8'h03, 1'b0, 1'b0));
        q1.push_back(mk(8'h04, 1'b0, 1'b0));
        q1.push_back(mk(8'h05, 1'b1, 1'b0));
        step(30);
        chk("ur_byte0", 16'({lv[t0+9], ld[t0+9]}), 16'h101);
        chk("ur_byte1", 16'({lv[t0+10], ld[t0+10]}), 16'h102);
        chk("ur_pulse_before", 16'(lur[t0+10]), 16'h0);
        chk("ur_pulse", 16'({lur[t0+11], lv[t0+11]}), 16'h2);
        chk("ur_pulse_after", 16'(lur[t0+12]), 16'h0);
        for (int i = 12; i <= 26; i++) chk("ur_drain_quiet", 16'(lv[t0+i]), 16'h0);
        for (int i = 1; i <= 27; i++) chk("ur_no_done", 16'(lfd[t0+i]), 16'h0);
        chk("ur_busy_ifg", 16'(lbusy[t0+26]), 16'h1);
        chk("ur_idle", 16'(lbusy[t0+27]), 16'h0);

        // Reset during payload byte 4, then fresh s1 request
        t0 = cyc + 1;
        q1.push_back(mk(8'hE1, 1'b0, 1'b0));
        q1.push_back(mk(8'hE2, 1'b0, 1'b0));
        q1.push_back(mk(8'hE3, 1'b0, 1'b0));
        q1.push_back(mk(8'hE4, 1'b0, 1'b0));
        q1.push_back(mk(8'hE5, 1'b0, 1'b0));
        q1.push_back(mk(8'hE6, 1'b1, 1'b0));
        step(13);
        rst = 1'b1;
        q1.delete();
        step(1);
        rst = 1'b0;
        chk("mrst_tx_valid", 16'(tx_valid), 16'h0);
        chk("mrst_busy", 16'(busy), 16'h0);
        chk("mrst_ready", 16'({s1_ready, s0_ready}), 16'h0);
        chk("mrst_grant", 16'(grant), 16'h0);
        t1 = cyc + 1;
        q1.push_back(mk(8'hF1, 1'b1, 1'b0));
        step(25);
        chk("mrst_byte4", 16'({lv[t0+12], ld[t0+12]}), 16'h1E4);
        chk("mrst_new_pre", 16'({lgr[t1+1], lv[t1+1], ld[t1+1]}), 16'h355);
        chk("mrst_new_sfd", 16'(ld[t1+8]), 16'hD5);
        chk("mrst_new_done", 16'({lfd[t1+9], ld[t1+9]}), 16'h1F1);

`ifdef ETH_TX_PAD_EN
        // 10-byte frame padded to 60
        t0 = cyc + 1;
        for (int i = 1; i <= 10; i++) q0.push_back(mk(8'(i), (i == 10), 1'b0));
        step(90);
        chk("pad_last_src", 16'({lfd[t0+18], ld[t0+18]}), 16'h00A);
        chk("pad_first", 16'({lv[t0+19], ld[t0+19]}), 16'h100);
        chk("pad_done", 16'({lfd[t0+68], lv[t0+68], ld[t0+68]}), 16'h300);
        chk("pad_end", 16'(lv[t0+69]), 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
